// File: rtl/sram_fifo_pkg.sv
// Shared types and helpers for the SRAM-backed streaming FIFO.
// Optional per-word last flag is enabled by defining SRAM_FIFO_LAST_EN.
package sram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DEPTH      = 512;
  localparam int CNT_WIDTH      = DEF_ADDR_WIDTH + 1;

  // Occupancy of the head/skid output stage.
  typedef enum logic [1:0] {
    OST_EMPTY = 2'd0,
    OST_ONE   = 2'd1,
    OST_TWO   = 2'd2
  } ost_e;

  // Pointers wrap at the configured depth, which need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_sdp.sv
// Simple-dual-port RAM: one write port, one registered read port, common clock.
// Read data appears one cycle after r_e; contents are never initialised.
module sram_sdp #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  w_e,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [WIDTH-1:0]      w_data,
  input  logic                  r_e,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [WIDTH-1:0]      r_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r_data_q;

  // NOTE: no reset here -- a reset would stop the array mapping onto RAM macros;
  // NOTE: non-blocking assignments keep read-before-write ordering between the ports.
  always_ff @(posedge clk) begin
    if (w_e) mem[w_addr] <= w_data;
    if (r_e) r_data_q <= mem[r_addr];
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/sram_stream_fifo.sv
// Valid/ready FIFO over an inferred SDP SRAM with a 2-entry first-word-fall-through stage.
// Define SRAM_FIFO_LAST_EN to carry a last flag per word and count stored packets.
module sram_stream_fifo
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
`ifdef SRAM_FIFO_LAST_EN
  input  logic                  i_last,
  output logic                  o_last,
  output logic [ADDR_WIDTH:0]   o_pkt_count,
`endif
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_afull,
  output logic                  o_empty
);

  localparam int CW = ADDR_WIDTH + 1;
`ifdef SRAM_FIFO_LAST_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         sram_cnt_q, sram_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  ost_e                  ost_q, ost_d;
  logic [SW-1:0]         head_q, head_d, skid_q, skid_d;
  logic [SW-1:0]         wr_word, rd_word;
  logic [1:0]            inflight;
  logic [CW-1:0]         count;
  logic                  wr_fire, rd_fire, rd_issue;

`ifdef SRAM_FIFO_LAST_EN
  logic [CW-1:0] pkt_q, pkt_d;
  assign wr_word     = {i_last, i_data};
  assign o_last      = head_q[SW-1];
  assign o_pkt_count = pkt_q;
`else
  assign wr_word = i_data;
`endif

  // Words owned by the output side: staged plus the one SRAM read in flight.
  assign inflight = 2'(ost_q) + 2'(rd_pend_q);
  assign count    = sram_cnt_q + CW'(inflight);

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_afull = (int'(count) >= AFULL_THRESH);
  assign i_ready = (int'(count) < DEPTH);
  assign o_valid = (ost_q != OST_EMPTY);
  assign o_data  = head_q[DATA_WIDTH-1:0];

  assign wr_fire  = i_valid && i_ready && !reset;
  assign rd_fire  = o_valid && o_ready;
  assign rd_issue = (sram_cnt_q != '0) &&
                    ((inflight < 2'd2) || (rd_fire && (inflight == 2'd2)));

  sram_sdp #(
    .WIDTH      (SW),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sram (
    .clk    (clk),
    .w_e    (wr_fire),
    .w_addr (wr_ptr_q),
    .w_data (wr_word),
    .r_e    (rd_issue),
    .r_addr (rd_ptr_q),
    .r_data (rd_word)
  );

  // NOTE: every signal gets its default first so no path leaves a latch behind.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_issue;
    ost_d      = ost_q;
    head_d     = head_q;
    skid_d     = skid_q;
    sram_cnt_d = sram_cnt_q + CW'(wr_fire) - CW'(rd_issue);

    if (wr_fire)  wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_issue) rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DEPTH));

    unique case (ost_q)
      OST_EMPTY: if (rd_pend_q) ost_d = OST_ONE;
      OST_ONE: begin
        if (rd_pend_q && !rd_fire)      ost_d = OST_TWO;
        else if (!rd_pend_q && rd_fire) ost_d = OST_EMPTY;
      end
      OST_TWO:   if (rd_fire) ost_d = OST_ONE;
      default:   ost_d = OST_EMPTY;
    endcase

    // Skid advances on consume; landing data takes the head only if it is free.
    if (rd_fire && (ost_q == OST_TWO)) head_d = skid_q;
    if (rd_pend_q) begin
      if ((ost_q == OST_EMPTY) || ((ost_q == OST_ONE) && rd_fire)) head_d = rd_word;
      else                                                         skid_d = rd_word;
    end
  end

`ifdef SRAM_FIFO_LAST_EN
  always_comb begin
    pkt_d = pkt_q + CW'(wr_fire && i_last) - CW'(rd_fire && o_last);
  end

  always_ff @(posedge clk) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      ost_q      <= OST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      ost_q      <= ost_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Self-checking bench for sram_stream_fifo: queue-based reference model, directed and random traffic.
// Exercises the last-flag path when SRAM_FIFO_LAST_EN is defined.
module tb_sram_stream_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 5;
  localparam int AFT   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_data;
  logic          i_valid, i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid, o_ready;
  logic [CW-1:0] o_count;
  logic          o_afull, o_empty;
`ifdef SRAM_FIFO_LAST_EN
  logic          i_last, o_last;
  logic [CW-1:0] o_pkt_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference contents in order: {last, data}.
  logic [DW:0] model_q[$];

  always #5 clk = ~clk;

  sram_stream_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
`ifdef SRAM_FIFO_LAST_EN
    .i_last      (i_last),
    .o_last      (o_last),
    .o_pkt_count (o_pkt_count),
`endif
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_count     (o_count),
    .o_afull     (o_afull),
    .o_empty     (o_empty)
  );

  function automatic int model_pkts();
    int n = 0;
    foreach (model_q[i]) n += int'(model_q[i][DW]);
    return n;
  endfunction

  // One clock of traffic starting at a falling edge; scoreboards the DUT against the model.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic wl, input logic rr);
    logic wf, rf;
    i_valid = wv;
    i_data  = wd;
    o_ready = rr;
`ifdef SRAM_FIFO_LAST_EN
    i_last  = wl;
`endif
    #1;
    vectors++;
    if (i_ready !== (model_q.size() < DEPTH)) begin
      miscompares++;
      $display("FAIL i_ready: got %b want %b", i_ready, (model_q.size() < DEPTH));
    end
    vectors++;
    if (o_valid === 1'b1 && model_q.size() == 0) begin
      miscompares++;
      $display("FAIL o_valid_when_empty: got %b want 0", o_valid);
    end
    if (o_valid === 1'b1 && model_q.size() > 0) begin
      vectors++;
      if (o_data !== model_q[0][DW-1:0]) begin
        miscompares++;
        $display("FAIL o_data: got %h want %h", o_data, model_q[0][DW-1:0]);
      end
`ifdef SRAM_FIFO_LAST_EN
      vectors++;
      if (o_last !== model_q[0][DW]) begin
        miscompares++;
        $display("FAIL o_last: got %b want %b", o_last, model_q[0][DW]);
      end
`endif
    end
    wf = wv && (i_ready === 1'b1);
    rf = rr && (o_valid === 1'b1);
    @(posedge clk);
    if (rf && model_q.size() > 0) void'(model_q.pop_front());
    if (wf) model_q.push_back({wl, wd});
    @(negedge clk);
    vectors++;
    if (o_count !== CW'(model_q.size())) begin
      miscompares++;
      $display("FAIL o_count: got %0d want %0d", o_count, model_q.size());
    end
    vectors++;
    if (o_empty !== (model_q.size() == 0)) begin
      miscompares++;
      $display("FAIL o_empty: got %b want %b", o_empty, (model_q.size() == 0));
    end
    vectors++;
    if (o_afull !== (model_q.size() >= AFT)) begin
      miscompares++;
      $display("FAIL o_afull: got %b want %b", o_afull, (model_q.size() >= AFT));
    end
`ifdef SRAM_FIFO_LAST_EN
    vectors++;
    if (o_pkt_count !== CW'(model_pkts())) begin
      miscompares++;
      $display("FAIL o_pkt_count: got %0d want %0d", o_pkt_count, model_pkts());
    end
`endif
  endtask

  // Reset for one edge with a write offered, which must be ignored.
  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b1;
    i_data  = 'h55;
    o_ready = 1'b0;
    @(posedge clk);
    model_q.delete();
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (model_q.size() > 0 && n < 40) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    vectors++;
    if (model_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: %0d words left, want 0", name, model_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b data=%h count=%0d want 0/0/0", o_valid, o_data, o_count);
    end
    vectors++;
    if (o_empty !== 1'b1 || o_afull !== 1'b0 || i_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: empty=%b afull=%b i_ready=%b want 1/0/1", o_empty, o_afull, i_ready);
    end
`ifdef SRAM_FIFO_LAST_EN
    vectors++;
    if (o_pkt_count !== '0) begin
      miscompares++;
      $display("FAIL reset_pkt_count: got %0d want 0", o_pkt_count);
    end
`endif
  endtask

  task automatic test_latency();
    logic [1:0] seen;
    do_reset();
    cycle(1'b1, 'h01, 1'b0, 1'b0);
    seen[0] = o_valid;
    cycle(1'b1, 'h02, 1'b0, 1'b0);
    seen[1] = o_valid;
    cycle(1'b1, 'h03, 1'b0, 1'b0);
    vectors++;
    if (seen !== 2'b00 || o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: valid after N,N+1,N+2 = %b%b%b want 001", seen[0], seen[1], o_valid);
    end
    vectors++;
    if (o_data !== 'h01 || o_count !== 4'd3 || o_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL first_word: data=%h count=%0d empty=%b want 01/3/0", o_data, o_count, o_empty);
    end
    drain("latency");
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'h10 + i), 1'b0, 1'b0);
    vectors++;
    if (i_ready !== 1'b0 || o_count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL full: i_ready=%b count=%0d want 0/%0d", i_ready, o_count, DEPTH);
    end
    cycle(1'b1, 'hEE, 1'b0, 1'b0);
    cycle(1'b1, 'hEF, 1'b0, 1'b1);
    vectors++;
    if (i_ready !== 1'b1 || o_count !== CW'(DEPTH - 1)) begin
      miscompares++;
      $display("FAIL after_pop: i_ready=%b count=%0d want 1/%0d", i_ready, o_count, DEPTH - 1);
    end
    cycle(1'b1, 'h20, 1'b0, 1'b0);
    drain("full_wrap");
  endtask

  task automatic test_back_to_back();
    int  bubbles = 0;
    bit  seen    = 1'b0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, DW'(i + 1), 1'b0, 1'b1);
      if (o_valid === 1'b1) seen = 1'b1;
      else if (seen) bubbles++;
    end
    vectors++;
    if (!seen || bubbles != 0) begin
      miscompares++;
      $display("FAIL stream_bubbles: seen=%0d bubbles=%0d want 1/0", seen, bubbles);
    end
    drain("stream");
  endtask

  task automatic test_random();
    int   burst = 0;
    logic wv    = 1'b0;
    void'($urandom(32'd20240611));
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (burst == 0) begin
        burst = int'($urandom_range(1, 8));
        wv    = 1'($urandom_range(0, 1));
      end
      burst--;
      cycle(wv, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("random");
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'h30 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    vectors++;
    if (o_valid !== 1'b0 || o_count !== '0 || i_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b count=%0d i_ready=%b want 0/0/1", o_valid, o_count, i_ready);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 'hAA, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 'hAA) begin
      miscompares++;
      $display("FAIL after_reset_head: valid=%b data=%h want 1/aa", o_valid, o_data);
    end
    drain("reset_inflight");
  endtask

`ifdef SRAM_FIFO_LAST_EN
  task automatic test_last();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'((i % 2) == 0), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (o_pkt_count !== 4'd2) begin
      miscompares++;
      $display("FAIL pkt_count_filled: got %0d want 2", o_pkt_count);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (o_data !== 'h2 || o_last !== 1'b1) begin
      miscompares++;
      $display("FAIL word2_last: data=%h last=%b want 2/1", o_data, o_last);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (o_pkt_count !== 4'd1) begin
      miscompares++;
      $display("FAIL pkt_count_after_read: got %0d want 1", o_pkt_count);
    end
    drain("last");
  endtask
`endif

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
`ifdef SRAM_FIFO_LAST_EN
    i_last  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_latency();
    test_full_wrap();
    test_back_to_back();
    test_random();
    test_reset_inflight();
`ifdef SRAM_FIFO_LAST_EN
    test_last();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
